// File: rtl/bcd_accumulator_pkg.sv
// Shared types and constants for the BCD accumulator.
// Segment patterns are active-low, bit 6 = a ... bit 0 = g.
package bcd_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic is_bcd(
    input logic [3:0] d
  );
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_accumulator_if.sv
// Request/response bundle between a controller and the accumulator.
// Master drives the request; slave returns result, status and display.
interface bcd_accumulator_if #(
  parameter int DIGITS = 2
);

  logic                  start;
  logic                  op;
  logic                  clear;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   sum;
  logic                  carry;
  logic                  error;
  logic                  busy;
  logic                  done;
  logic [7*DIGITS-1:0]   hex;

  modport master (
    output start,
    output op,
    output clear,
    output a,
    input  sum,
    input  carry,
    input  error,
    input  busy,
    input  done,
    input  hex
  );

  modport slave (
    input  start,
    input  op,
    input  clear,
    input  a,
    output sum,
    output carry,
    output error,
    output busy,
    output done,
    output hex
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// One BCD digit to active-low a..g segments.
// Non-decimal codes blank the digit.
module bcd_to_7seg
  import bcd_accumulator_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_accumulator.sv
// Digit-serial BCD add/subtract accumulator with 7-segment display.
// Sum updates only at commit; subtraction uses ten's complement.
module bcd_accumulator
  import bcd_accumulator_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  bcd_accumulator_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t state;
  state_t state_nx;

  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  work;
  logic [W-1:0]  work_nx;
  logic [W-1:0]  sum_q;
  logic          op_q;
  logic          cy;
  logic          carry_q;
  logic          error_q;

  logic          a_ok;
  logic          last;
  logic [3:0]    s_dig;
  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [3:0]    r_dig;
  logic [4:0]    t;
  logic          c_nx;

  always_comb begin
    a_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!is_bcd(bus.a[4*k +: 4])) a_ok = 1'b0;
    end
  end

  assign last = (idx == IW'(DIGITS - 1));

  // One digit per cycle; subtract adds the nines' complement
  // with the initial carry set, giving ten's complement.
  always_comb begin
    s_dig = sum_q[4*idx +: 4];
    a_dig = a_q[4*idx +: 4];
    b_dig = op_q ? (BCD_MAX - a_dig) : a_dig;
    t     = {1'b0, s_dig} + {1'b0, b_dig} + {4'b0, cy};
    if (t > {1'b0, BCD_MAX}) begin
      r_dig = 4'(t - 5'd10);
      c_nx  = 1'b1;
    end else begin
      r_dig = t[3:0];
      c_nx  = 1'b0;
    end
    work_nx = work;
    work_nx[4*idx +: 4] = r_dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.clear) begin
          state_nx = a_ok ? ADD : DONE;
        end
      end
      ADD:  if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      a_q     <= '0;
      work    <= '0;
      sum_q   <= '0;
      op_q    <= 1'b0;
      cy      <= 1'b0;
      carry_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.clear) begin
            sum_q   <= '0;
            work    <= '0;
            carry_q <= 1'b0;
            error_q <= 1'b0;
          end else if (bus.start) begin
            if (a_ok) begin
              a_q  <= bus.a;
              op_q <= bus.op;
              idx  <= '0;
              cy   <= bus.op;
              work <= sum_q;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        ADD: begin
          work <= work_nx;
          cy   <= c_nx;
          idx  <= idx + 1'b1;
          if (last) begin
            sum_q   <= work_nx;
            carry_q <= op_q ? ~c_nx : c_nx;
            error_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign bus.error = error_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_7seg u_seg (
      .bcd (sum_q[4*g +: 4]),
      .seg (bus.hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_bcd_accumulator.sv
// Directed bench for bcd_accumulator with DIGITS=2.
// Expected values are hand-computed BCD results.
module tb_bcd_accumulator;

  localparam int DIGITS = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   n0;
  int   cyc;

  bcd_accumulator_if #(.DIGITS(DIGITS)) bus ();

  bcd_accumulator #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic o,
                        input logic [7:0] av, input int exp_cyc);
    bus.op    = o;
    bus.a     = av;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 12) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_cyc);
    tick();
    chk({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.clear = 1'b0;
    bus.a     = '0;
    tick();
    tick();
    chk("rst_sum", bus.sum, 8'h00);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_error", bus.error, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_hex", bus.hex, {7'b0000001, 7'b0000001});
    rst = 1'b0;
    tick();

    run_op("add45", 1'b0, 8'h45, 3);
    chk("add45_sum", bus.sum, 8'h45);
    chk("add45_carry", bus.carry, 1'b0);
    chk("add45_hex1", bus.hex[13:7], 7'b1001100);
    chk("add45_hex0", bus.hex[6:0], 7'b0100100);

    run_op("add67", 1'b0, 8'h67, 3);
    chk("add67_sum", bus.sum, 8'h12);
    chk("add67_carry", bus.carry, 1'b1);

    run_op("sub05", 1'b1, 8'h05, 3);
    chk("sub05_sum", bus.sum, 8'h07);
    chk("sub05_carry", bus.carry, 1'b0);

    run_op("sub20", 1'b1, 8'h20, 3);
    chk("sub20_sum", bus.sum, 8'h87);
    chk("sub20_carry", bus.carry, 1'b1);
    chk("sub20_hex", bus.hex, {7'b0000000, 7'b0001111});

    run_op("bad3c", 1'b0, 8'h3C, 1);
    chk("bad3c_error", bus.error, 1'b1);
    chk("bad3c_sum", bus.sum, 8'h87);
    chk("bad3c_carry", bus.carry, 1'b1);

    run_op("add01", 1'b0, 8'h01, 3);
    chk("add01_sum", bus.sum, 8'h88);
    chk("add01_carry", bus.carry, 1'b0);
    chk("add01_error", bus.error, 1'b0);

    // Second Start while busy must be dropped.
    n0 = done_cnt;
    bus.op    = 1'b0;
    bus.a     = 8'h11;
    bus.start = 1'b1;
    tick();
    chk("dbl_busy", bus.busy, 1'b1);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("dbl_done_cnt", done_cnt - n0, 1);
    chk("dbl_sum", bus.sum, 8'h99);
    chk("dbl_busy_end", bus.busy, 1'b0);

    // Reset in the middle of ADD.
    n0 = done_cnt;
    bus.a     = 8'h11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("mid_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_sum", bus.sum, 8'h00);
    chk("mid_busy_rst", bus.busy, 1'b0);
    chk("mid_done", bus.done, 1'b0);
    chk("mid_hex", bus.hex, {7'b0000001, 7'b0000001});
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("mid_no_done", done_cnt - n0, 0);
    chk("mid_sum_after", bus.sum, 8'h00);

    run_op("neg05", 1'b1, 8'h05, 3);
    chk("neg05_sum", bus.sum, 8'h95);
    chk("neg05_carry", bus.carry, 1'b1);

    // Clear beats a simultaneous Start.
    n0 = done_cnt;
    bus.clear = 1'b1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 8'h22;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk("clr_sum", bus.sum, 8'h00);
    chk("clr_carry", bus.carry, 1'b0);
    chk("clr_busy", bus.busy, 1'b0);
    repeat (4) tick();
    chk("clr_no_done", done_cnt - n0, 0);
    chk("clr_busy_end", bus.busy, 1'b0);
    chk("clr_sum_end", bus.sum, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_accumulator.md
BCD_ACCUMULATOR -- requirements
Module: bcd_accumulator

Interface
REQ-001 Parameter DIGITS, default 2, SHALL set the number of BCD digits; legal values are 1..8.
REQ-002 Clock  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 Reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 Start  in  1  SHALL request one operation, sampled only in IDLE.
REQ-005 Op  in  1  SHALL select the operation: 0 = Sum+A, 1 = Sum-A (ten's complement); sampled with Start.
REQ-006 Clear  in  1  SHALL zero the accumulator; sampled only in IDLE.
REQ-007 A  in  4*DIGITS  SHALL be the BCD operand, digit k at bits [4k+3:4k]; sampled with Start.
REQ-008 Sum  out  4*DIGITS  SHALL be the committed BCD accumulator.
REQ-009 Carry  out  1  SHALL flag add overflow (Op=0) or subtract borrow (Op=1).
REQ-010 Error  out  1  SHALL flag that the last operand contained a digit greater than 9.
REQ-011 Busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-012 Done  out  1  SHALL pulse for one cycle per completed operation.
REQ-013 HEX  out  7*DIGITS  SHALL drive active-low segments a..g, one 7-bit group per Sum digit.

Function
REQ-014 FSM states SHALL be IDLE, ADD and DONE; IDLE is the reset state.
REQ-015 IDLE with Start=1, Clear=0 and every A digit <= 9: latch A and Op, set digit index=0, set carry=Op, go to ADD.
REQ-016 IDLE with Start=1, Clear=0 and any A digit > 9: set Error=1, leave Sum and Carry unchanged, go to DONE.
REQ-017 In ADD, one digit SHALL be processed per cycle, least-significant first: b = A digit (Op=0) or 9-A digit (Op=1); t = Sum digit + b + carry (5-bit).
REQ-018 If t > 9, the result digit SHALL be t-10 and the carry 1; otherwise the result digit is t and the carry 0.
REQ-019 Result digits SHALL go to a working register; Sum SHALL stay stable until commit.
REQ-020 After digit DIGITS-1 the FSM SHALL go to DONE and commit Sum from the working register in the same edge.
REQ-021 At commit, Carry SHALL equal the final carry for Op=0 and the inverted final carry for Op=1.
REQ-022 At commit, Error SHALL be 0.
REQ-023 DONE SHALL last exactly one cycle, assert Done, then return to IDLE.
REQ-024 Latency: with Start sampled at edge 0, Done SHALL be high in cycle DIGITS+1 (valid operand) or cycle 1 (Error).
REQ-025 Start and Clear SHALL be ignored while Busy=1; no request is queued.
REQ-026 Clear in IDLE SHALL zero Sum, Carry and Error; Clear SHALL win over a simultaneous Start, which is dropped.
REQ-027 HEX SHALL be a combinational decode of Sum, where 0 = 0000001 and 8 = 0000000 in a..g order.
REQ-028 Arithmetic SHALL wrap modulo 10^DIGITS; a negative subtract result SHALL stay in Sum as its ten's complement with Carry=1.

Reset
REQ-029 Reset=1 SHALL force IDLE and set Sum, working register, Carry, Error, Busy and Done to 0, and the HEX digits to 0000001, regardless of the clock.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no partial commit and no Done pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the BCD limit constant (9) and the ten active-low segment constants.
REQ-032 One sub-module, bcd_to_7seg (4-bit BCD in, 7-bit active-low segments out), SHALL be instantiated DIGITS times.

Verification (DIGITS=2)
REQ-033 Reset, then Start Op=0 A=0x45 -> Done in cycle 3; Sum=0x45, Carry=0, HEX1=1001100, HEX0=0100100.
REQ-034 Next, Start Op=0 A=0x67 -> Sum=0x12, Carry=1; then Start Op=1 A=0x05 -> Sum=0x07, Carry=0.
REQ-035 Next, Start Op=1 A=0x20 -> Sum=0x87, Carry=1 (borrow).
REQ-036 Start A=0x3C -> Error=1 and Done in cycle 1; Sum unchanged; the next valid operation clears Error.
REQ-037 Start a second time while Busy=1 -> ignored, exactly one Done pulse; Reset asserted during ADD -> Sum=0, Busy=0, no Done.
REQ-038 Clear and Start in the same IDLE cycle -> Sum=0, Carry=0, Busy stays 0, no Done.
